data_mem_access: RTL
====================

DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 mem_read  in  4  [3] load enable; [2:0] funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-005 mem_write  in  3  [2] store enable; [1:0] funct3[1:0] (00 SB, 01 SH, 10 SW).
REQ-006 address  in  32  byte address from ALU.
REQ-007 write_data  in  32  store data (rs2).
REQ-008 read_data  out  32  formatted load result, registered.
REQ-009 busywait  out  1  pipeline stall request.
REQ-010 misaligned  out  1  one-cycle misalignment flag (only with MISALIGN_TRAP_EN).
REQ-011 mem_req  out  1  backing-memory request, registered.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
REQ-013 mem_addr  out  30  word address, address[31:2].
REQ-014 mem_wdata  out  32  lane-replicated store data.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_rdata  in  32  backing-memory read word, valid with mem_ack.
REQ-017 mem_ack  in  1  backing-memory completion.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and DONE.
REQ-019 In IDLE with a legal access, the block SHALL latch address, data and type, and move to WAIT on the next edge.
REQ-020 busywait SHALL be combinational: high in IDLE when a legal access is presented, and high throughout WAIT.
REQ-021 mem_req, mem_we, mem_addr, mem_wdata and mem_be SHALL be driven from latched values and held stable for the whole of WAIT.
REQ-022 When mem_ack is high in WAIT, the block SHALL register read_data (loads only), drop mem_req and enter DONE.
REQ-023 In DONE, busywait SHALL be low for exactly one cycle and the block SHALL return to IDLE; requests seen in DONE SHALL NOT start an access.
REQ-024 Minimum access latency SHALL be 2 cycles of busywait, then 1 DONE cycle, when mem_ack arrives in the first WAIT cycle.
REQ-025 mem_ack seen in IDLE or DONE SHALL be ignored.
REQ-026 If load and store enables are both high, the store SHALL win.
REQ-027 Load funct3 011, 110 or 111 SHALL be illegal: no access, no busywait, read_data unchanged.
REQ-028 Store byte enables: SB = 4'b0001 << address[1:0]; SH = 4'b0011 (address[1]=0) or 4'b1100 (address[1]=1); SW = 4'b1111; funct3[1:0] = 11 is illegal and SHALL be ignored.
REQ-029 Store data: SB replicates byte [7:0] into all four lanes; SH replicates halfword [15:0] into both halves; SW passes the word through.
REQ-030 Load formatting: LB/LBU take byte lane address[1:0], LH/LHU take half lane address[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes the word through.
REQ-031 read_data SHALL hold its value until the next completed load.

Reset
REQ-032 While reset is high, the state SHALL go to IDLE and read_data, mem_req, mem_we, mem_addr, mem_wdata, mem_be and misaligned SHALL all be 0.
REQ-033 While reset is high, busywait SHALL be 0 regardless of the request inputs.
REQ-034 Reset during WAIT SHALL abort the access, and a coincident mem_ack SHALL be discarded.

Configuration
REQ-035 The macro MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-036 When MISALIGN_TRAP_EN is defined, a halfword access with address[0]=1, or a word access with address[1:0]≠0, SHALL be detected in IDLE. On detection: misaligned pulses high for one cycle, no backing-memory access occurs, busywait stays low, and read_data is unchanged.
REQ-037 When MISALIGN_TRAP_EN is undefined, misaligned SHALL be tied to 0 and the offending low address bits SHALL be treated as 0 (halfword: address[0]; word: address[1:0]).

Verification
REQ-038 SW, address 0x100, write_data 0xDEADBEEF, ack after 3 WAIT cycles -> mem_addr 0x40, mem_be 1111, mem_wdata 0xDEADBEEF, busywait high for 4 cycles, then DONE for 1 cycle.
REQ-039 LB, address 0x203, mem_rdata 0x80FF_FF7F -> read_data 0xFFFFFF80; LBU at the same address and data -> read_data 0x00000080.
REQ-040 SH, address 0x06, write_data 0x0000A5C3 -> mem_be 1100, mem_wdata 0xA5C3A5C3.
REQ-041 Reset asserted in the second WAIT cycle with mem_ack high on that same edge -> next cycle IDLE, mem_req 0, read_data 0.
REQ-042 LW, address 0x102: with MISALIGN_TRAP_EN -> misaligned 1 for one cycle, mem_req stays 0; without it -> access to mem_addr 0x40.
REQ-043 Load and store enables both high at address 0x10 -> mem_we 1 and a single access; mem_ack presented in IDLE -> no state change.

Source files
------------

// File: rtl/data_mem_access.sv
// ---------------------------------------------------------------------------
// data_mem_access
//
// Load/store unit placed between the pipeline and a simple request/acknowledge
// backing memory. It accepts one access at a time and stalls the pipeline with
// busywait until the memory acknowledges. It then spends one DONE cycle with
// busywait low before it accepts a new request.
//
// Ports
//   clock       in   sole clock, rising-edge
//   reset       in   synchronous, active-high
//   mem_read    in   [3] load enable, [2:0] funct3 (LB/LH/LW/LBU/LHU)
//   mem_write   in   [2] store enable, [1:0] funct3[1:0] (SB/SH/SW)
//   address     in   byte address
//   write_data  in   store data
//   read_data   out  formatted load result (registered, held until next load)
//   busywait    out  combinational stall request
//   misaligned  out  one-cycle misalignment pulse (trap build only)
//   mem_req     out  backing-memory request (registered)
//   mem_we      out  1 = write, 0 = read
//   mem_addr    out  word address
//   mem_wdata   out  lane-replicated store data
//   mem_be      out  byte enables
//   mem_rdata   in   backing-memory read word
//   mem_ack     in   backing-memory completion
//
// Configuration
//   MISALIGN_TRAP_EN  when defined, the block traps misaligned halfword and
//                     word accesses: misaligned pulses and no access starts.
//                     When undefined, the block ignores the offending low
//                     address bits and misaligned stays 0.
// ---------------------------------------------------------------------------
module data_mem_access (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  mem_read,
    input  logic [2:0]  mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        busywait,
    output logic        misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] read_data_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [29:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [2:0]  ld_f3_q;
    logic [1:0]  lo_q;

    logic        is_store_s;
    logic        ld_ok_s;
    logic        req_s;
    logic [1:0]  size_s;
    logic [1:0]  lo_s;
    logic        trap_s;
    logic        start_s;

    // Store byte enables from access size (00 byte, 01 half, 10 word).
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store operand into every lane it could land in.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Select the addressed lane of the returned word and extend it.
    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Request decode: legality, access size and effective low address bits.
    always_comb begin
        is_store_s = mem_write[2];
        ld_ok_s    = 1'b0;
        req_s      = 1'b0;
        size_s     = 2'b00;
        lo_s       = address[1:0];

        case (mem_read[2:0])
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_ok_s = 1'b1;
            default:                                ld_ok_s = 1'b0;
        endcase

        // A raised store enable always takes priority, even if its size is illegal.
        if (is_store_s) begin
            req_s  = (mem_write[1:0] != 2'b11);
            size_s = mem_write[1:0];
        end else begin
            req_s  = mem_read[3] & ld_ok_s;
            size_s = mem_read[1:0];
        end

        // Low bits below the access size never influence lane selection.
        case (size_s)
            2'b01:   lo_s = {address[1], 1'b0};
            2'b10:   lo_s = 2'b00;
            default: lo_s = address[1:0];
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_s;
    logic misaligned_q;

    // Misalignment detection for halfword and word accesses.
    always_comb begin
        case (size_s)
            2'b01:   mis_s = address[0];
            2'b10:   mis_s = (address[1:0] != 2'b00);
            default: mis_s = 1'b0;
        endcase
        trap_s = req_s & mis_s;
    end

    // One-cycle misalignment pulse for a trapped request seen in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= (state_q == S_IDLE) & trap_s;
        end
    end

    assign misaligned = misaligned_q;
`else
    assign trap_s     = 1'b0;
    assign misaligned = 1'b0;
`endif

    assign start_s  = (state_q == S_IDLE) & req_s & ~trap_s;
    // Reset masks the stall so a request during reset never freezes the pipeline.
    assign busywait = ~reset & (start_s | (state_q == S_WAIT));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_s ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = mem_ack ? S_DONE : S_WAIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, request latch and load result register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            read_data_q <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 30'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            ld_f3_q     <= 3'b000;
            lo_q        <= 2'b00;
        end else begin
            state_q <= state_d;
            if (start_s) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= is_store_s;
                mem_addr_q  <= address[31:2];
                mem_wdata_q <= is_store_s ? store_data(size_s, write_data) : 32'h0000_0000;
                mem_be_q    <= is_store_s ? store_be(size_s, lo_s) : 4'b1111;
                ld_f3_q     <= mem_read[2:0];
                lo_q        <= lo_s;
            end else if ((state_q == S_WAIT) && mem_ack) begin
                mem_req_q <= 1'b0;
                if (!mem_we_q) begin
                    read_data_q <= load_fmt(ld_f3_q, lo_q, mem_rdata);
                end else begin
                    read_data_q <= read_data_q;
                end
            end else begin
                mem_req_q <= mem_req_q;
            end
        end
    end

    assign read_data = read_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
